// File: rtl/execute_memory_register_pkg.sv
// Shared processor package for the EX/MEM pipeline boundary.
// Holds the datapath widths and the packed layouts of the control and data
// bundles that cross from execute into memory.
package execute_memory_register_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int COUNT_W    = 32;

  typedef struct packed {
    logic valid;
    logic pc_src;
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0]     alu_out;
    logic [DATA_W-1:0]     write_data;
    logic [REG_ADDR_W-1:0] wa3;
  } data_t;

  // An annulled instruction must not redirect the PC or change
  // architectural state, so its side-effecting controls are forced low.
  // MemtoReg only steers the writeback mux and is passed through untouched.
  function automatic ctrl_t qualify_ctrl(input logic valid,
                                         input logic pc_src,
                                         input logic reg_write,
                                         input logic mem_write,
                                         input logic mem_to_reg);
    ctrl_t c;
    c.valid      = valid;
    c.pc_src     = pc_src & valid;
    c.reg_write  = reg_write & valid;
    c.mem_write  = mem_write & valid;
    c.mem_to_reg = mem_to_reg;
    return c;
  endfunction

endpackage

// File: rtl/execute_memory_register_pipeline_reg.sv
// pipeline_reg: generic pipeline flop stage.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset, clears q
//   en   - load d into q
//   clr  - synchronous clear of q; wins over en
//   d, q - WIDTH-bit data in / registered out
module pipeline_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/execute_memory_register.sv
// execute_memory_register: EX/MEM pipeline register with retirement and
// taken-branch counters.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   StallM, FlushM      - hold / bubble controls (flush wins over stall)
//   ValidE              - execute stage holds a real instruction
//   PCSrcECU, RegWriteECU, MemWriteECU, MemtoRegE, BranchTakenE - EX controls
//   ALUResultE, WriteDataE, WA3E - EX data fields
//   PCSrcM, RegWriteM, MemWriteM, MemtoRegM, ValidM - registered controls
//   ALUOutM, WriteDataM, WA3M    - registered data fields
//   RetiredCount, BranchCount    - instructions / taken branches advanced
module execute_memory_register
  import execute_memory_register_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallM,
  input  logic                  FlushM,
  input  logic                  ValidE,
  input  logic                  PCSrcECU,
  input  logic                  RegWriteECU,
  input  logic                  MemWriteECU,
  input  logic                  BranchTakenE,
  input  logic                  MemtoRegE,
  input  logic [DATA_W-1:0]     ALUResultE,
  input  logic [DATA_W-1:0]     WriteDataE,
  input  logic [REG_ADDR_W-1:0] WA3E,
  output logic                  PCSrcM,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  MemtoRegM,
  output logic                  ValidM,
  output logic [DATA_W-1:0]     ALUOutM,
  output logic [DATA_W-1:0]     WriteDataM,
  output logic [REG_ADDR_W-1:0] WA3M,
  output logic [COUNT_W-1:0]    RetiredCount,
  output logic [COUNT_W-1:0]    BranchCount
);

  localparam int CTRL_W = $bits(ctrl_t);
  localparam int DATA_BUNDLE_W = $bits(data_t);

  logic  load;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  data_t data_d;
  data_t data_q;

  logic [COUNT_W-1:0] retired_count_reg;
  logic [COUNT_W-1:0] retired_count_next;
  logic [COUNT_W-1:0] branch_count_reg;
  logic [COUNT_W-1:0] branch_count_next;

  // A flush alone (or with stall) is a bubble, never a load.
  assign load = ~FlushM & ~StallM;

  assign ctrl_d = qualify_ctrl(ValidE, PCSrcECU, RegWriteECU, MemWriteECU, MemtoRegE);

  assign data_d.alu_out    = ALUResultE;
  assign data_d.write_data = WriteDataE;
  assign data_d.wa3        = WA3E;

  // Controls are cleared on flush; since clear beats enable inside the
  // stage, flush+stall still produces a bubble.
  pipeline_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (~StallM),
    .clr (FlushM),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  // Data fields keep their old contents through a bubble.
  pipeline_reg #(.WIDTH(DATA_BUNDLE_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (load),
    .clr (1'b0),
    .d   (data_d),
    .q   (data_q)
  );

  always_comb begin
    retired_count_next = retired_count_reg;
    branch_count_next  = branch_count_reg;
    if (load && ValidE) begin
      retired_count_next = retired_count_reg + COUNT_W'(1);
      if (BranchTakenE) begin
        branch_count_next = branch_count_reg + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_count_reg <= '0;
      branch_count_reg  <= '0;
    end else begin
      retired_count_reg <= retired_count_next;
      branch_count_reg  <= branch_count_next;
    end
  end

  assign ValidM       = ctrl_q.valid;
  assign PCSrcM       = ctrl_q.pc_src;
  assign RegWriteM    = ctrl_q.reg_write;
  assign MemWriteM    = ctrl_q.mem_write;
  assign MemtoRegM    = ctrl_q.mem_to_reg;
  assign ALUOutM      = data_q.alu_out;
  assign WriteDataM   = data_q.write_data;
  assign WA3M         = data_q.wa3;
  assign RetiredCount = retired_count_reg;
  assign BranchCount  = branch_count_reg;

endmodule

// File: doc/execute_memory_register.md
EXECUTE_MEMORY_REGISTER -- requirements
Module: execute_memory_register

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- StallM  in  1  hold current EX/MEM contents.
- FlushM  in  1  load a bubble.
- ValidE  in  1  execute stage holds a real instruction.
- PCSrcECU, RegWriteECU, MemWriteECU  in  1 each  condition-qualified controls from conditional_unit.
- BranchTakenE  in  1  branch resolved taken in execute.
- MemtoRegE  in  1  writeback selects memory data.
- ALUResultE  in  32  ALU result or address.
- WriteDataE  in  32  store data.
- WA3E  in  4  destination register.
- PCSrcM, RegWriteM, MemWriteM, MemtoRegM  out  1 each  registered controls.
- ValidM  out  1  memory stage holds a real instruction.
- ALUOutM  out  32  registered ALUResultE.
- WriteDataM  out  32  registered WriteDataE.
- WA3M  out  4  registered WA3E.
- RetiredCount  out  32  instructions advanced into memory stage.
- BranchCount  out  32  taken branches advanced into memory stage.

Function
REQ-002 The update priority SHALL be: reset > FlushM > StallM > load.
REQ-003 On load (FlushM=0, StallM=0), every M output SHALL take its E input one cycle later; ValidM SHALL take ValidE; latency is exactly 1 cycle.
REQ-004 When ValidE=0 on load, PCSrcM, RegWriteM and MemWriteM SHALL be loaded as 0 regardless of their CU inputs; data fields SHALL load unchanged.
REQ-005 On FlushM=1, ValidM, PCSrcM, RegWriteM, MemWriteM and MemtoRegM SHALL become 0; ALUOutM, WriteDataM and WA3M SHALL hold.
REQ-006 On StallM=1 with FlushM=0, all outputs including both counters SHALL hold.
REQ-007 FlushM=1 with StallM=1 SHALL produce a bubble; flush wins.
REQ-008 RetiredCount SHALL increment by 1 on each load cycle with ValidE=1.
REQ-009 BranchCount SHALL increment by 1 on each load cycle with ValidE=1 and BranchTakenE=1.
REQ-010 Counters SHALL be unsigned 32-bit and wrap from 0xFFFFFFFF to 0x00000000 without a flag.
REQ-011 Counters SHALL NOT increment on flush or stall cycles.
REQ-012 All outputs SHALL come directly from flops; there SHALL be no combinational input-to-output path.

Reset
REQ-013 When rst=0, all outputs and counters SHALL clear to 0 immediately, independent of clk.
REQ-014 Reset asserted mid-stall or mid-flush SHALL override both.
REQ-015 The first rising edge after rst deasserts SHALL perform a normal priority evaluation per REQ-002.

Structure
REQ-016 The data width (32) and register-address width (4) SHALL be constants in the shared processor package; no local literals.
REQ-017 A generic parameterized sub-module pipeline_reg SHALL implement the flop stages. It SHALL have a width parameter, enable and clear inputs, and asynchronous active-low reset. It SHALL be instantiated once for control fields and once for data fields.
REQ-018 The counters SHALL reside in execute_memory_register, not in pipeline_reg.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Load: ValidE=1, RegWriteECU=1, MemWriteECU=0, ALUResultE=0x0000_00A5, WA3E=4'h3 -> next cycle RegWriteM=1, ALUOutM=0x0000_00A5, WA3M=4'h3, RetiredCount=1.
- Annulled instruction: ValidE=0, RegWriteECU=1, MemWriteECU=1 -> RegWriteM=0, MemWriteM=0, RetiredCount unchanged.
- Stall: StallM=1 for 3 cycles while inputs toggle -> all outputs and counters hold the pre-stall values.
- Flush and stall together: FlushM=1, StallM=1 with a valid store pending -> ValidM=0, MemWriteM=0, ALUOutM held, counters unchanged.
- Taken branch: ValidE=1, BranchTakenE=1, PCSrcECU=1 -> PCSrcM=1, BranchCount=1.
- Wrap: preload RetiredCount=0xFFFFFFFF, one valid load -> RetiredCount=0x00000000.
- Reset mid-operation: assert rst=0 between clock edges -> all outputs 0 before the next edge.
